// File: rtl/gray_seq_checker.sv
// Gray-sequence checker: decodes a 4-bit Gray word, validates single-step transitions, tracks lock/direction, counts violations.
// Latency: one clock from an enabled sampling edge to Y, step pulses, dir, locked and err_cnt.
// Backpressure: none; en=0 freezes all state and suppresses pulses for that cycle.
module gray_seq_checker #(
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             c,
    input  logic             en,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    output logic [3:0]       Y,
    output logic             step_ok,
    output logic             step_err,
    output logic             dir,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    localparam logic [3:0] LOCK_THR = 4'(LOCK_CNT);

    state_t           state, state_nxt;
    logic [3:0]       p, p_nxt, good, good_nxt, y_nxt;
    logic [3:0]       b, delta, good_inc;
    logic             dir_nxt, ok_nxt, err_nxt;
    logic             is_up, is_dn, is_step, viol;
    logic [ERR_W-1:0] err_cnt_nxt, err_cnt_inc;

    assign b        = {A, A ^ B, A ^ B ^ C, A ^ B ^ C ^ D};
    assign delta    = b - p;
    assign is_up    = (delta == 4'd1);
    assign is_dn    = (delta == 4'hF);
    assign is_step  = is_up | is_dn;
    assign viol     = (delta != 4'd0) && !is_step;
    assign good_inc = (is_up == dir) ? good + 4'd1 : 4'd1;
    // Counter sticks at all-ones; step_err keeps pulsing independently.
    assign err_cnt_inc = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);

    always_ff @(posedge clk or negedge c) begin
        if (!c) begin
            state    <= IDLE;
            Y        <= 4'd0;
            p        <= 4'd0;
            good     <= 4'd0;
            dir      <= 1'b1;
            step_ok  <= 1'b0;
            step_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            Y        <= y_nxt;
            p        <= p_nxt;
            good     <= good_nxt;
            dir      <= dir_nxt;
            step_ok  <= ok_nxt;
            step_err <= err_nxt;
            err_cnt  <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        y_nxt       = Y;
        p_nxt       = p;
        good_nxt    = good;
        dir_nxt     = dir;
        ok_nxt      = 1'b0;
        err_nxt     = 1'b0;
        err_cnt_nxt = err_cnt;
        if (en) begin
            // Always re-synchronise to the new sample, even after a violation.
            p_nxt = b;
            y_nxt = b;
            case (state)
                IDLE: begin
                    state_nxt = ACQ;
                    good_nxt  = 4'd0;
                end
                ACQ: begin
                    if (is_step) begin
                        ok_nxt   = 1'b1;
                        dir_nxt  = is_up;
                        good_nxt = good_inc;
                        if (good_inc >= LOCK_THR) state_nxt = LOCKED;
                    end else if (viol) begin
                        err_nxt     = 1'b1;
                        err_cnt_nxt = err_cnt_inc;
                        good_nxt    = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_step && (is_up == dir)) begin
                        ok_nxt = 1'b1;
                    end else if (is_step) begin
                        // Reversal is a violation but already one good step the other way.
                        err_nxt     = 1'b1;
                        err_cnt_nxt = err_cnt_inc;
                        dir_nxt     = is_up;
                        good_nxt    = 4'd1;
                        state_nxt   = ACQ;
                    end else if (viol) begin
                        err_nxt     = 1'b1;
                        err_cnt_nxt = err_cnt_inc;
                        good_nxt    = 4'd0;
                        state_nxt   = ACQ;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

endmodule
